pingpong_frame_scheduler: RTL and testbench
===========================================

// Module: pingpong_frame_scheduler
// PURPOSE
//   Sequences the ping-pong input sample buffer into the downstream DSP core.
//   Waits for a full frame and acknowledges it so the writer swaps to the other buffer.
//   Streams the captured frame one sample per accepted handshake, then waits for core completion.
//   Sits between the input buffer and the processing core; counts served frames and writer overruns.
// PARAMETERS
//   DATA_WIDTH      16   sample width in bits
//   BUFFER_SIZE     256  samples per frame; power of two, >=2
//   WAIT_CORE_DONE  1    1: hold in WAIT_DONE until core_done; 0: return to IDLE after last sample
//   CNT_WIDTH       16   width of frame_count and overrun_count
// PORTS
//   clk                   in   1                       system clock, rising edge
//   reset_n               in   1                       asynchronous reset, active-low
//   enable                in   1                       permit acceptance of new frames
//   ready_for_processing  in   1                       buffer reports a full frame
//   buffer_select         in   1                       buffer currently written (0=a, 1=b)
//   buffer_flat_a         in   DATA_WIDTH*BUFFER_SIZE  buffer a; sample i at [(i+1)*DW-1 -: DW]
//   buffer_flat_b         in   DATA_WIDTH*BUFFER_SIZE  buffer b; same packing
//   ready_ack             out  1                       one-cycle frame acknowledge to buffer
//   out_data              out  DATA_WIDTH              current sample to core
//   out_valid             out  1                       out_data valid
//   out_last              out  1                       out_data is sample BUFFER_SIZE-1
//   out_ready             in   1                       core accepts sample this cycle
//   core_done             in   1                       core finished frame (pulse or level)
//   busy                  out  1                       state != IDLE
//   frame_count           out  CNT_WIDTH               frames completed; wraps
//   overrun_count         out  CNT_WIDTH               overrun events; saturates at all-ones
// BEHAVIOUR
//   Reset (reset_n=0, async):
//     state=IDLE; ready_ack=0, out_valid=0, out_last=0, busy=0, out_data=0.
//     rd_idx=0, frame_sel=0, frame_count=0, overrun_count=0, rfp_d=0.
//     Mid-frame reset abandons the frame; no ack is reissued.
//   FSM IDLE -> ACK -> STREAM -> [WAIT_DONE] -> IDLE; all outputs registered or decoded from registers.
//   IDLE: if enable && ready_for_processing, then frame_sel<=buffer_select, ready_ack<=1, go to ACK.
//   ACK: ready_ack high exactly this one cycle; rd_idx<=0; go to STREAM.
//     Frame captured = buffer frame_sel; writer now fills the other buffer.
//   STREAM: out_valid=1; out_data=sample rd_idx of buffer frame_sel; out_last=(rd_idx==BUFFER_SIZE-1).
//     A transfer occurs when out_valid && out_ready; then rd_idx increments.
//     out_data and out_last hold stable while out_ready=0.
//     On the last transfer: if WAIT_CORE_DONE go to WAIT_DONE, else frame_count++ and go to IDLE.
//   WAIT_DONE: out_valid=0; core_done=1 -> frame_count++, go to IDLE.
//   Latency: rfp seen in IDLE at cycle T -> ready_ack at T+1 -> first out_valid at T+2.
//   Back-to-back: rfp already high on return to IDLE -> ack issued in the next cycle; zero extra idle.
//   enable deasserted mid-frame: current frame completes; no new frame accepted.
//   core_done in IDLE, ACK or STREAM: ignored.
//   Overrun: rfp_d registers ready_for_processing.
//     A rising edge (rfp && !rfp_d) while state != IDLE increments overrun_count (saturating).
//   rd_idx width = $clog2(BUFFER_SIZE); no wrap occurs within a frame.
//   frame_count wraps modulo 2^CNT_WIDTH.
// STRUCTURE
//   Package dsp_ctrl_pkg: FSM state encodings (IDLE=0, ACK=1, STREAM=2, WAIT_DONE=3), SEL_A/SEL_B constants.
//   Sub-module frame_sample_mux:
//     Combinational select of sample rd_idx from buffer_flat_a or buffer_flat_b per frame_sel.
//     Its output is registered into out_data in this block.
// TESTING
//   1. Single frame: rfp=1, buffer_select=0, out_ready=1.
//      -> ready_ack 1 cycle, 256 samples of buffer a in order, out_last on idx 255, busy until core_done.
//   2. Backpressure: toggle out_ready 1010...
//      -> exactly 256 transfers, data stable during stalls, no sample dropped or repeated.
//   3. Ping-pong: two frames, buffer_select 0 then 1.
//      -> frame 1 streams from a, frame 2 from b; frame_count=2.
//   4. Overrun: rfp re-rises during STREAM.
//      -> overrun_count=1; next ack issued the cycle after return to IDLE.
//   5. Reset mid-STREAM at idx 100 -> all outputs 0 next edge, counters 0.
//      After release with rfp=1, a fresh ack is issued.
//   6. WAIT_CORE_DONE=0, enable dropped mid-frame
//      -> frame completes to IDLE without core_done; no further ack while enable=0.

Source files
------------

// File: rtl/dsp_ctrl_pkg.sv
// Shared encodings for the ping-pong frame scheduler: FSM states and buffer select values.
package dsp_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACK       = 2'd1,
        STREAM    = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/frame_sample_mux.sv
// Combinational pick of one sample from either ping-pong buffer.
module frame_sample_mux
    import dsp_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int BUFFER_SIZE = 256,
    parameter int IDX_W       = $clog2(BUFFER_SIZE)
) (
    input  logic [DATA_WIDTH*BUFFER_SIZE-1:0] buffer_flat_a,
    input  logic [DATA_WIDTH*BUFFER_SIZE-1:0] buffer_flat_b,
    input  logic                              frame_sel,
    input  logic [IDX_W-1:0]                  idx,
    output logic [DATA_WIDTH-1:0]             sample
);

    // Sample i lives at [(i+1)*DW-1 -: DW], which is exactly element i of this packed view.
    logic [BUFFER_SIZE-1:0][DATA_WIDTH-1:0] arr_a;
    logic [BUFFER_SIZE-1:0][DATA_WIDTH-1:0] arr_b;

    assign arr_a  = buffer_flat_a;
    assign arr_b  = buffer_flat_b;
    assign sample = (frame_sel == SEL_B) ? arr_b[idx] : arr_a[idx];

endmodule

// File: rtl/pingpong_frame_scheduler.sv
// Streams a captured ping-pong frame into the DSP core and counts served frames and overruns.
//   state     | meaning
//   IDLE      | waiting for enable && ready_for_processing
//   ACK       | one-cycle ready_ack, writer swaps buffers
//   STREAM    | one sample per out_valid && out_ready handshake
//   WAIT_DONE | frame sent, waiting for core_done
module pingpong_frame_scheduler #(
    parameter int DATA_WIDTH     = 16,
    parameter int BUFFER_SIZE    = 256,
    parameter bit WAIT_CORE_DONE = 1'b1,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              enable,
    input  logic                              ready_for_processing,
    input  logic                              buffer_select,
    input  logic [DATA_WIDTH*BUFFER_SIZE-1:0] buffer_flat_a,
    input  logic [DATA_WIDTH*BUFFER_SIZE-1:0] buffer_flat_b,
    output logic                              ready_ack,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_valid,
    output logic                              out_last,
    input  logic                              out_ready,
    input  logic                              core_done,
    output logic                              busy,
    output logic [CNT_WIDTH-1:0]              frame_count,
    output logic [CNT_WIDTH-1:0]              overrun_count
);
    import dsp_ctrl_pkg::*;

    localparam int              IDX_W    = $clog2(BUFFER_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUFFER_SIZE - 1);

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        rd_idx, rd_idx_nxt;
    logic                    frame_sel;
    logic                    rfp_d;
    logic                    xfer;
    logic                    frame_done;
    logic [DATA_WIDTH-1:0]   mux_sample;

    assign xfer = out_valid && out_ready;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        rd_idx_nxt = rd_idx;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (enable && ready_for_processing) state_nxt = ACK;
            end
            ACK: begin
                state_nxt  = STREAM;
                rd_idx_nxt = '0;
            end
            STREAM: begin
                if (xfer) begin
                    if (rd_idx == LAST_IDX) begin
                        if (WAIT_CORE_DONE) begin
                            state_nxt = WAIT_DONE;
                        end else begin
                            state_nxt  = IDLE;
                            frame_done = 1'b1;
                        end
                    end else begin
                        rd_idx_nxt = rd_idx + 1'b1;
                    end
                end
            end
            WAIT_DONE: begin
                if (core_done) begin
                    state_nxt  = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The mux looks one index ahead so out_data is already correct when STREAM presents it.
    frame_sample_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUFFER_SIZE(BUFFER_SIZE),
        .IDX_W      (IDX_W)
    ) u_mux (
        .buffer_flat_a(buffer_flat_a),
        .buffer_flat_b(buffer_flat_b),
        .frame_sel    (frame_sel),
        .idx          (rd_idx_nxt),
        .sample       (mux_sample)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_idx        <= '0;
            frame_sel     <= SEL_A;
            rfp_d         <= 1'b0;
            ready_ack     <= 1'b0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            out_data      <= '0;
            frame_count   <= '0;
            overrun_count <= '0;
        end else begin
            rd_idx    <= rd_idx_nxt;
            rfp_d     <= ready_for_processing;
            ready_ack <= (state_nxt == ACK);
            out_valid <= (state_nxt == STREAM);
            out_last  <= (state_nxt == STREAM) && (rd_idx_nxt == LAST_IDX);
            if (state == IDLE && state_nxt == ACK) frame_sel <= buffer_select;
            if (state_nxt == STREAM) out_data <= mux_sample;
            if (frame_done) frame_count <= frame_count + CNT_WIDTH'(1);
            if (ready_for_processing && !rfp_d && state != IDLE && overrun_count != '1)
                overrun_count <= overrun_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pingpong_frame_scheduler.sv
// Directed bench: main instance waits for core_done, second instance returns to IDLE after the last sample.
module tb_pingpong_frame_scheduler;

    localparam int DW = 16;
    localparam int N  = 256;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [DW*N-1:0] buf_a, buf_b;
    logic bsel = 1'b0;

    logic enable = 1'b0, rfp = 1'b0, out_ready = 1'b0, core_done = 1'b0;
    logic ready_ack, out_valid, out_last, busy;
    logic [DW-1:0] out_data;
    logic [CW-1:0] frame_count, overrun_count;

    logic en1 = 1'b0, rfp1 = 1'b0, ordy1 = 1'b0, cdone1 = 1'b0;
    logic ack1, val1, last1, busy1;
    logic [DW-1:0] dat1;
    logic [CW-1:0] fc1, oc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pingpong_frame_scheduler #(.DATA_WIDTH(DW), .BUFFER_SIZE(N), .WAIT_CORE_DONE(1'b1), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .ready_for_processing(rfp),
        .buffer_select(bsel), .buffer_flat_a(buf_a), .buffer_flat_b(buf_b),
        .ready_ack(ready_ack), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .core_done(core_done), .busy(busy),
        .frame_count(frame_count), .overrun_count(overrun_count));

    pingpong_frame_scheduler #(.DATA_WIDTH(DW), .BUFFER_SIZE(N), .WAIT_CORE_DONE(1'b0), .CNT_WIDTH(CW)) dut_nowait (
        .clk(clk), .reset_n(reset_n), .enable(en1), .ready_for_processing(rfp1),
        .buffer_select(bsel), .buffer_flat_a(buf_a), .buffer_flat_b(buf_b),
        .ready_ack(ack1), .out_data(dat1), .out_valid(val1), .out_last(last1),
        .out_ready(ordy1), .core_done(cdone1), .busy(busy1),
        .frame_count(fc1), .overrun_count(oc1));

    function automatic logic [DW-1:0] samp(input logic sel, input int i);
        return sel ? (16'hB000 + 16'(i)) : (16'hA000 + 16'(i));
    endfunction

    task automatic test_reset();
        checks++;
        if ({ready_ack, out_valid, out_last, busy} !== 4'b0 || out_data !== '0 ||
            frame_count !== '0 || overrun_count !== '0) begin
            errors++;
            $display("FAIL reset_state: ack=%b valid=%b last=%b busy=%b data=%h fc=%0d oc=%0d, expected all zero",
                     ready_ack, out_valid, out_last, busy, out_data, frame_count, overrun_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Caller is at a negedge; leaves at the negedge where the first sample is presented.
    task automatic start_frame(input logic sel);
        enable = 1'b1; rfp = 1'b1; bsel = sel;
        @(negedge clk);
        checks++;
        if (ready_ack !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_ack: ack=%b valid=%b busy=%b, expected ack=1 valid=0 busy=1", ready_ack, out_valid, busy);
        end
        rfp = 1'b0;
        @(negedge clk);
        checks++;
        if (ready_ack !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ack_one_cycle: ack=%b valid=%b, expected ack=0 valid=1", ready_ack, out_valid);
        end
    endtask

    task automatic collect_frame(input logic sel, input bit bp);
        int idx = 0;
        int cyc = 0;
        logic rdy;
        while (idx < N) begin
            if (cyc > 4*N) begin
                errors++;
                $display("FAIL stream_timeout: transfers=%0d, expected %0d", idx, N);
                break;
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== samp(sel, idx) || out_last !== (idx == N-1)) begin
                errors++;
                $display("FAIL stream sel=%0d idx=%0d: got valid=%b data=%h last=%b, expected valid=1 data=%h last=%b",
                         sel, idx, out_valid, out_data, out_last, samp(sel, idx), (idx == N-1));
            end
            rdy = bp ? ((cyc % 2) == 0) : 1'b1;
            out_ready = rdy;
            @(negedge clk);
            if (rdy) idx++;
            cyc++;
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL after_last: valid=%b busy=%b, expected valid=0 busy=1", out_valid, busy);
        end
    endtask

    task automatic finish_frame(input int exp_fc);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || frame_count !== CW'(exp_fc - 1)) begin
            errors++;
            $display("FAIL wait_done_hold: busy=%b fc=%0d, expected busy=1 fc=%0d", busy, frame_count, exp_fc - 1);
        end
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || frame_count !== CW'(exp_fc)) begin
            errors++;
            $display("FAIL frame_done: busy=%b fc=%0d, expected busy=0 fc=%0d", busy, frame_count, exp_fc);
        end
    endtask

    task automatic test_single_frame();
        out_ready = 1'b1;
        start_frame(1'b0);
        collect_frame(1'b0, 1'b0);
        finish_frame(1);
    endtask

    task automatic test_backpressure();
        start_frame(1'b0);
        collect_frame(1'b0, 1'b1);
        finish_frame(2);
    endtask

    task automatic test_pingpong();
        start_frame(1'b0);
        collect_frame(1'b0, 1'b0);
        finish_frame(3);
        start_frame(1'b1);
        collect_frame(1'b1, 1'b0);
        finish_frame(4);
    endtask

    task automatic test_overrun_back_to_back();
        start_frame(1'b0);
        rfp = 1'b1; bsel = 1'b1;
        collect_frame(1'b0, 1'b0);
        checks++;
        if (overrun_count !== CW'(1)) begin
            errors++;
            $display("FAIL overrun_count: got %0d, expected 1", overrun_count);
        end
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || ready_ack !== 1'b0 || frame_count !== CW'(5)) begin
            errors++;
            $display("FAIL return_idle: busy=%b ack=%b fc=%0d, expected busy=0 ack=0 fc=5", busy, ready_ack, frame_count);
        end
        @(negedge clk);
        checks++;
        if (ready_ack !== 1'b1 || overrun_count !== CW'(1)) begin
            errors++;
            $display("FAIL back_to_back_ack: ack=%b oc=%0d, expected ack=1 oc=1", ready_ack, overrun_count);
        end
        rfp = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_stream();
        out_ready = 1'b1;
        repeat (100) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== samp(1'b1, 100) || out_last !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_idx100: valid=%b data=%h last=%b, expected valid=1 data=%h last=0",
                     out_valid, out_data, out_last, samp(1'b1, 100));
        end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({ready_ack, out_valid, out_last, busy} !== 4'b0 || out_data !== '0 ||
            frame_count !== '0 || overrun_count !== '0) begin
            errors++;
            $display("FAIL mid_reset: ack=%b valid=%b last=%b busy=%b data=%h fc=%0d oc=%0d, expected all zero",
                     ready_ack, out_valid, out_last, busy, out_data, frame_count, overrun_count);
        end
        @(negedge clk);
        enable = 1'b1; rfp = 1'b1; bsel = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_ack !== 1'b1 || overrun_count !== '0) begin
            errors++;
            $display("FAIL ack_after_reset: ack=%b oc=%0d, expected ack=1 oc=0", ready_ack, overrun_count);
        end
        rfp = 1'b0;
        @(negedge clk);
        collect_frame(1'b0, 1'b0);
        finish_frame(1);
    endtask

    task automatic test_no_wait_enable_drop();
        int k = 0;
        int cyc = 0;
        enable = 1'b0;
        bsel = 1'b0; en1 = 1'b1; rfp1 = 1'b1; ordy1 = 1'b1;
        @(negedge clk);
        checks++;
        if (ack1 !== 1'b1) begin
            errors++;
            $display("FAIL nowait_ack: got %b, expected 1", ack1);
        end
        rfp1 = 1'b0;
        @(negedge clk);
        en1 = 1'b0; rfp1 = 1'b1;
        while (k < N) begin
            if (cyc > 2*N) begin
                errors++;
                $display("FAIL nowait_timeout: transfers=%0d, expected %0d", k, N);
                break;
            end
            if (val1 === 1'b1) begin
                checks++;
                if (dat1 !== samp(1'b0, k) || last1 !== (k == N-1)) begin
                    errors++;
                    $display("FAIL nowait_stream idx=%0d: data=%h last=%b, expected data=%h last=%b",
                             k, dat1, last1, samp(1'b0, k), (k == N-1));
                end
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (val1 !== 1'b0 || busy1 !== 1'b0 || fc1 !== CW'(1) || oc1 !== CW'(1)) begin
            errors++;
            $display("FAIL nowait_complete: valid=%b busy=%b fc=%0d oc=%0d, expected valid=0 busy=0 fc=1 oc=1",
                     val1, busy1, fc1, oc1);
        end
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (ack1 !== 1'b0 || busy1 !== 1'b0) begin
                errors++;
                $display("FAIL nowait_no_accept: ack=%b busy=%b, expected ack=0 busy=0", ack1, busy1);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            buf_a[i*DW +: DW] = 16'hA000 + 16'(i);
            buf_b[i*DW +: DW] = 16'hB000 + 16'(i);
        end
        #12;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_pingpong();
        test_overrun_back_to_back();
        test_reset_mid_stream();
        test_no_wait_enable_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
